neural_layer_sequencer: RTL and testbench

//  Controller that sequences one fully-connected layer through the accelerator MAC datapath.
//  For each output neuron j it clears the accumulator and streams N_IN input/weight reads.
//  It then pulses activation and writes the result to output memory.

---
 rtl/neural_layer_sequencer.sv | 136 +++++++++++++
 tb/tb_neural_layer_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/neural_layer_sequencer.sv
// Sequencer for one fully-connected layer: per neuron it clears the MAC, streams N_IN
// input/weight reads, drains the read pipeline, pulses activation and writes the result.
module neural_layer_sequencer #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 3,
  parameter int IN_AW  = 2,
  parameter int OUT_AW = 2,
  parameter int W_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IN_AW-1:0]  in_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              act_en,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_ACT   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] J_LAST = OUT_AW'(N_OUT - 1);

  state_t             state_r;
  logic [IN_AW-1:0]   i_r;
  logic [OUT_AW-1:0]  j_r;
  logic [W_AW-1:0]    wcnt_r;

  assign in_addr = i_r;

  // FSM with registered outputs: each transition loads the outputs of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      i_r      <= {IN_AW{1'b0}};
      j_r      <= {OUT_AW{1'b0}};
      wcnt_r   <= {W_AW{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      w_addr   <= {W_AW{1'b0}};
      mac_clr  <= 1'b0;
      mac_en   <= 1'b0;
      act_en   <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= {OUT_AW{1'b0}};
    end else begin
      mac_clr <= 1'b0;
      rd_en   <= 1'b0;
      act_en  <= 1'b0;
      out_we  <= 1'b0;
      done    <= 1'b0;
      // read data returns one cycle after the strobe
      mac_en  <= rd_en;
      if (abort) begin
        state_r <= S_IDLE;
        busy    <= 1'b0;
        mac_en  <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start) begin
              state_r <= S_CLR;
              busy    <= 1'b1;
              mac_clr <= 1'b1;
              j_r     <= {OUT_AW{1'b0}};
              wcnt_r  <= {W_AW{1'b0}};
            end else begin
              busy <= 1'b0;
            end
          end
          S_CLR: begin
            state_r <= S_ACC;
            rd_en   <= 1'b1;
            i_r     <= {IN_AW{1'b0}};
            w_addr  <= wcnt_r;
            wcnt_r  <= wcnt_r + W_AW'(1);
          end
          S_ACC: begin
            if (i_r == I_LAST) begin
              state_r <= S_DRAIN;
            end else begin
              rd_en  <= 1'b1;
              i_r    <= i_r + IN_AW'(1);
              w_addr <= wcnt_r;
              wcnt_r <= wcnt_r + W_AW'(1);
            end
          end
          S_DRAIN: begin
            state_r <= S_ACT;
            act_en  <= 1'b1;
          end
          S_ACT: begin
            state_r  <= S_WRITE;
            out_we   <= 1'b1;
            out_addr <= j_r;
          end
          S_WRITE: begin
            if (j_r == J_LAST) begin
              state_r <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= S_CLR;
              mac_clr <= 1'b1;
              j_r     <= j_r + OUT_AW'(1);
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// Directed bench for neural_layer_sequencer: default 4x3 layer plus a 1x1 instance.
module tb_neural_layer_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
  logic busy, done, rd_en, mac_clr, mac_en, act_en, out_we;
  logic [1:0] in_addr, out_addr;
  logic [3:0] w_addr;
  logic r1_busy, r1_done, r1_rd_en, r1_mac_clr, r1_mac_en, r1_act_en, r1_out_we;
  logic [0:0] r1_in_addr, r1_w_addr, r1_out_addr;

  int checks = 0, failures = 0;

  // observation record of the last pass
  int nreads, nwrites, ndone, done_cyc, busy_cyc, nmac, mac_bad, excl_bad;
  int rd_in [0:63];
  int rd_w  [0:63];
  int wr_a  [0:63];
  int wr_c  [0:63];
  bit clr_at[0:63];
  bit mac_at[0:63];

  always #5 clk = ~clk;

  neural_layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_en(rd_en), .in_addr(in_addr), .w_addr(w_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .act_en(act_en), .out_we(out_we), .out_addr(out_addr)
  );

  neural_layer_sequencer #(.N_IN(1), .N_OUT(1), .IN_AW(1), .OUT_AW(1), .W_AW(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1), .busy(r1_busy), .done(r1_done),
    .rd_en(r1_rd_en), .in_addr(r1_in_addr), .w_addr(r1_w_addr), .mac_clr(r1_mac_clr),
    .mac_en(r1_mac_en), .act_en(r1_act_en), .out_we(r1_out_we), .out_addr(r1_out_addr)
  );

  // Called at a negedge: pulses start, then records ncyc cycles; extra start pulses / abort driven at given cycles.
  task automatic observe(input int ncyc, input int p1, input int p2, input int abort_cyc);
    logic prev_rd, prev_ab;
    nreads = 0; nwrites = 0; ndone = 0; done_cyc = -1; busy_cyc = 0;
    nmac = 0; mac_bad = 0; excl_bad = 0;
    for (int k = 0; k < 64; k++) begin clr_at[k] = 1'b0; mac_at[k] = 1'b0; end
    prev_rd = 1'b0; prev_ab = 1'b0;
    start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (rd_en) begin rd_in[nreads] = int'(in_addr); rd_w[nreads] = int'(w_addr); nreads++; end
      if (mac_en !== (prev_rd & ~prev_ab)) mac_bad++;
      if (mac_en) begin nmac++; mac_at[k] = 1'b1; end
      if (mac_clr) clr_at[k] = 1'b1;
      if (out_we) begin wr_a[nwrites] = int'(out_addr); wr_c[nwrites] = k; nwrites++; end
      if (done) begin ndone++; done_cyc = k; end
      if (busy) busy_cyc++;
      if ((int'(mac_clr) + int'(act_en) + int'(out_we) + int'(done)) > 1) excl_bad++;
      prev_rd = rd_en;
      if (k == p1 || k == p2) start = 1'b1;
      if (k == abort_cyc) abort = 1'b1;
      prev_ab = abort;
    end
  endtask

  task automatic check_full_pass(input string tag);
    checks++; if (nreads !== 12) begin failures++; $display("FAIL %s_nreads got=%0d exp=12", tag, nreads); end
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_in[j*4+i] !== i || rd_w[j*4+i] !== j*4+i) begin
          failures++;
          $display("FAIL %s_read%0d got in=%0d w=%0d exp in=%0d w=%0d", tag, j*4+i, rd_in[j*4+i], rd_w[j*4+i], i, j*4+i);
        end
      end
    checks++; if (nwrites !== 3) begin failures++; $display("FAIL %s_nwrites got=%0d exp=3", tag, nwrites); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (wr_a[j] !== j || wr_c[j] !== 8*(j+1)) begin
        failures++; $display("FAIL %s_write%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d", tag, j, wr_a[j], wr_c[j], j, 8*(j+1));
      end
    end
    checks++; if (ndone !== 1 || done_cyc !== 25) begin failures++; $display("FAIL %s_done got n=%0d cyc=%0d exp n=1 cyc=25", tag, ndone, done_cyc); end
    checks++; if (busy_cyc !== 25) begin failures++; $display("FAIL %s_busy got=%0d exp=25", tag, busy_cyc); end
    checks++; if (nmac !== 12 || mac_bad !== 0) begin failures++; $display("FAIL %s_mac_en got n=%0d bad=%0d exp n=12 bad=0", tag, nmac, mac_bad); end
    checks++; if (excl_bad !== 0) begin failures++; $display("FAIL %s_exclusive got=%0d exp=0", tag, excl_bad); end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (clr_at[8*j+1] !== 1'b1 || mac_at[8*j+2] !== 1'b0 || mac_at[8*j+3] !== 1'b1) begin
        failures++; $display("FAIL %s_clr_lead%0d got clr=%0b mac+1=%0b mac+2=%0b exp 1 0 1", tag, j, clr_at[8*j+1], mac_at[8*j+2], mac_at[8*j+3]);
      end
    end
  endtask

  task automatic test_reset();
    #4 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, rd_en, mac_clr, mac_en, act_en, out_we, in_addr, w_addr, out_addr} !== 15'd0) begin
        failures++; $display("FAIL reset_outputs got=%h exp=0", {busy, done, rd_en, mac_clr, mac_en, act_en, out_we, in_addr, w_addr, out_addr});
      end
    end
  endtask

  task automatic test_single_pass();
    observe(30, -1, -1, -1);
    check_full_pass("pass");
  endtask

  task automatic test_start_ignored();
    observe(30, 3, 10, -1);
    check_full_pass("restart");
  endtask

  task automatic test_start_in_done();
    observe(30, 25, -1, -1);
    checks++; if (busy_cyc !== 25 || ndone !== 1) begin failures++; $display("FAIL start_in_done got busy=%0d done=%0d exp 25 1", busy_cyc, ndone); end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1; abort = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++; if (busy !== 1'b0 || mac_clr !== 1'b0) begin failures++; $display("FAIL start_abort_idle got busy=%0b clr=%0b exp 0 0", busy, mac_clr); end
    end
  endtask

  task automatic test_abort();
    observe(30, -1, -1, 11);
    checks++; if (nreads !== 6) begin failures++; $display("FAIL abort_nreads got=%0d exp=6", nreads); end
    checks++; if (nwrites !== 1 || wr_a[0] !== 0) begin failures++; $display("FAIL abort_writes got=%0d exp=1", nwrites); end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", ndone); end
    checks++; if (busy_cyc !== 11) begin failures++; $display("FAIL abort_busy got=%0d exp=11", busy_cyc); end
    checks++; if (mac_bad !== 0) begin failures++; $display("FAIL abort_mac_en got=%0d exp=0", mac_bad); end
    observe(30, -1, -1, -1);
    check_full_pass("after_abort");
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, rd_en, mac_clr, mac_en, act_en, out_we, in_addr, w_addr, out_addr} !== 15'd0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", {busy, done, rd_en, mac_clr, mac_en, act_en, out_we, in_addr, w_addr, out_addr});
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL async_reset_hold got busy=%0b done=%0b exp 0 0", busy, done); end
    reset = 1'b0;
    @(negedge clk);
    observe(30, -1, -1, -1);
    check_full_pass("after_reset");
  endtask

  task automatic test_min_layer();
    int nr, wa, wec, dc;
    nr = 0; wa = -1; wec = -1; dc = -1;
    start1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (r1_rd_en) begin nr++; wa = int'(r1_w_addr); end
      if (r1_out_we) wec = k;
      if (r1_done) dc = k;
    end
    checks++; if (nr !== 1 || wa !== 0) begin failures++; $display("FAIL min_reads got n=%0d w=%0d exp n=1 w=0", nr, wa); end
    checks++; if (wec !== 5) begin failures++; $display("FAIL min_out_we got=%0d exp=5", wec); end
    checks++; if (dc !== 6) begin failures++; $display("FAIL min_done got=%0d exp=6", dc); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_start_ignored();
    test_start_in_done();
    test_start_abort_idle();
    test_abort();
    test_async_reset();
    test_min_layer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
